line_decoder_3to8: RTL and testbench
====================================

# line_decoder_3to8

3-to-8 line decoder with active-high enable, providing a combinational one-hot output and a registered copy for downstream synchronous logic. It also keeps a registered record of the selected line and a sticky record of every line asserted since the last clear. It sits between control/address logic and per-line select consumers (chip selects, mux enables).

## Interface

No parameters; all widths are fixed.

- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  reset, synchronous and active-high; one clock; clears all registered outputs.
- Enable  input  1  decode enable, active-high.
- A  input  1  select bit 2 (MSB).
- B  input  1  select bit 1.
- C  input  1  select bit 0 (LSB).
- clear_seen  input  1  synchronous clear of the seen mask, active-high.
- F  output  8  combinational one-hot decode output.
- F_q  output  8  F registered one cycle.
- valid_q  output  1  registered Enable.
- sel_q  output  3  registered select index {A,B,C}.
- seen_q  output  8  sticky OR of all F values since the last reset or clear.

## Operation

- Index idx = {A,B,C}, with A as MSB and range 0..7.
- Combinational path:
  - F = 8'b0 when Enable = 0, regardless of A, B and C.
  - F = (8'b1 << idx) when Enable = 1, so exactly bit F[idx] is 1.
  - F depends only on Enable, A, B and C; it ignores clk and rst and settles within the same delta/timestep.
- Registered path, on each rising clk edge:
  - If rst = 1: F_q = 0, valid_q = 0, sel_q = 0, seen_q = 0.
  - Else: F_q = F, valid_q = Enable, sel_q = idx.
  - sel_q is captured even when Enable = 0. Consumers must qualify it with valid_q.
- seen_q:
  - If rst = 1 or clear_seen = 1: seen_q = 0.
  - Else: seen_q = seen_q | F.
  - When clear_seen and a nonzero F coincide, clear wins; that cycle's F is not recorded.
- Invariants:
  - F and F_q are always either zero or exactly one-hot.
  - F_q is nonzero iff valid_q = 1.
  - F_q == (valid_q ? 8'b1 << sel_q : 0).
- Any X or Z on an input must not be masked in simulation. Use a case/shift form; do not use default-to-zero tricks on unknown selects.

## Timing

- F has zero-cycle latency and is purely combinational.
- F_q, valid_q and sel_q have a latency of 1 cycle from the inputs.
- seen_q reflects a line asserted at edge N from edge N onward.
- Reset values of every registered output are zero.
- Reset mid-operation clears the registers at the next edge and leaves F unaffected.
- rst has priority over clear_seen; both are synchronous.
- No handshake: the block accepts new inputs every cycle.

## Test plan

- Enable=0, {A,B,C}=3'b110, no clock edge, wait 5 time units -> F = 8'b00000000.
- Enable=1, sweep idx 0..7 combinationally -> F = 8'b00000001, 8'b00000010, … 8'b10000000; then Enable=0 at each idx -> F = 0.
- Assert rst for one edge, then Enable=1, idx=5 -> F_q/valid_q/sel_q/seen_q all 0 right after the reset edge; one edge later F_q = 8'b00100000, valid_q = 1, sel_q = 5.
- Enable=1 with idx 1, 3, 7 on successive edges, then Enable=0 -> seen_q = 8'b10001010 and remains there while Enable=0.
- clear_seen=1 with Enable=1, idx=2 on the same edge -> seen_q = 0 after that edge; next edge with clear_seen=0 and idx=2 -> seen_q = 8'b00000100.
- rst=1 while Enable=1, idx=4 -> F = 8'b00010000 combinationally, and F_q = 0, seen_q = 0 after the edge.

Source files
------------

// File: rtl/line_decoder_3to8.sv
// 3-to-8 one-hot line decoder with a registered copy of the decode, the
// captured select/enable, and a sticky per-line "seen" mask.

module line_decoder_lane (
    input  logic clk,
    input  logic rst,
    input  logic f,
    input  logic clear_seen,
    output logic f_q,
    output logic seen_q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q <= 1'b0;
        end else begin
            f_q <= f;
        end
    end

    // Clear beats a same-cycle assertion: that cycle's line is not recorded.
    always_ff @(posedge clk) begin
        if (rst || clear_seen) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_q | f;
        end
    end
endmodule

module line_decoder_3to8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       Enable,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       clear_seen,
    output logic [7:0] F,
    output logic [7:0] F_q,
    output logic       valid_q,
    output logic [2:0] sel_q,
    output logic [7:0] seen_q
);
    localparam int NUM_LINES = 8;

    logic [2:0] idx;

    assign idx = {A, B, C};

    // Shift form keeps an unknown select visible as X instead of folding to zero.
    always_comb begin
        F = '0;
        case (Enable)
            1'b0:    F = '0;
            1'b1:    F = 8'b1 << idx;
            default: F = 'x;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sel_q   <= 3'd0;
        end else begin
            valid_q <= Enable;
            sel_q   <= idx;
        end
    end

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_lane
        line_decoder_lane u_lane (
            .clk        (clk),
            .rst        (rst),
            .f          (F[i]),
            .clear_seen (clear_seen),
            .f_q        (F_q[i]),
            .seen_q     (seen_q[i])
        );
    end
endmodule

// File: tb/tb_line_decoder_3to8.sv
// Self-checking bench: decode table, directed register sequences, then random
// traffic against a behavioural model of the decoder and its registers.

module tb_line_decoder_3to8;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Enable = 1'b0;
    logic       A = 1'b0, B = 1'b0, C = 1'b0;
    logic       clear_seen = 1'b0;
    logic [7:0] F, F_q, seen_q;
    logic       valid_q;
    logic [2:0] sel_q;

    int n_checks = 0;
    int n_fail   = 0;

    line_decoder_3to8 dut (
        .clk        (clk),
        .rst        (rst),
        .Enable     (Enable),
        .A          (A),
        .B          (B),
        .C          (C),
        .clear_seen (clear_seen),
        .F          (F),
        .F_q        (F_q),
        .valid_q    (valid_q),
        .sel_q      (sel_q),
        .seen_q     (seen_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        int         idx;
        logic [7:0] exp_f;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic en, input int idx);
        Enable = en;
        A = idx[2];
        B = idx[1];
        C = idx[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decode is 2**idx when enabled, else nothing.
    function automatic logic [7:0] ref_f(input logic en, input int idx);
        int v;
        v = en ? (2 ** idx) : 0;
        return v[7:0];
    endfunction

    vec_t tbl[$];
    logic [7:0] m_fq, m_seen;
    logic       m_valid;
    logic [2:0] m_sel;

    initial begin
        vec_t v;
        // Decode table: every index enabled, then every index disabled.
        for (int i = 0; i < 8; i++) begin
            v.en = 1'b1; v.idx = i; v.exp_f = 8'h01 << i;
            tbl.push_back(v);
        end
        for (int i = 0; i < 8; i++) begin
            v.en = 1'b0; v.idx = i; v.exp_f = 8'h00;
            tbl.push_back(v);
        end

        // Disabled with select 6, no reliance on a clock edge.
        set_in(1'b0, 6);
        #5;
        check("f_disabled_idx6", {24'd0, F}, 32'h00);

        foreach (tbl[k]) begin
            set_in(tbl[k].en, tbl[k].idx);
            #1;
            check($sformatf("f_table_%0d", k), {24'd0, F}, {24'd0, tbl[k].exp_f});
        end

        // Reset edge with a live input, then the first captured decode.
        rst = 1'b1; set_in(1'b1, 5);
        tick();
        check("rst_fq",    {24'd0, F_q},    32'h00);
        check("rst_valid", {31'd0, valid_q}, 32'h0);
        check("rst_sel",   {29'd0, sel_q},  32'h0);
        check("rst_seen",  {24'd0, seen_q}, 32'h00);
        rst = 1'b0;
        tick();
        check("cap_fq",    {24'd0, F_q},    32'h20);
        check("cap_valid", {31'd0, valid_q}, 32'h1);
        check("cap_sel",   {29'd0, sel_q},  32'd5);
        check("cap_seen",  {24'd0, seen_q}, 32'h20);

        // Sticky accumulation of lines 1, 3, 7.
        clear_seen = 1'b1; set_in(1'b0, 0);
        tick();
        clear_seen = 1'b0;
        set_in(1'b1, 1); tick();
        set_in(1'b1, 3); tick();
        set_in(1'b1, 7); tick();
        set_in(1'b0, 2); tick();
        check("seen_137",      {24'd0, seen_q}, 32'h8A);
        check("disabled_fq",   {24'd0, F_q},    32'h00);
        check("disabled_sel",  {29'd0, sel_q},  32'd2);
        tick();
        check("seen_137_hold", {24'd0, seen_q}, 32'h8A);

        // Clear coinciding with an assertion wins.
        clear_seen = 1'b1; set_in(1'b1, 2);
        tick();
        check("clear_wins", {24'd0, seen_q}, 32'h00);
        clear_seen = 1'b0;
        tick();
        check("after_clear", {24'd0, seen_q}, 32'h04);

        // Reset while enabled: F unaffected, registers cleared; rst beats clear.
        rst = 1'b1; clear_seen = 1'b1; set_in(1'b1, 4);
        #1;
        check("f_during_rst", {24'd0, F}, 32'h10);
        tick();
        check("rst_mid_fq",   {24'd0, F_q},    32'h00);
        check("rst_mid_seen", {24'd0, seen_q}, 32'h00);
        rst = 1'b0; clear_seen = 1'b0;

        // Random traffic against the model; model state is all-zero after reset.
        m_fq = '0; m_seen = '0; m_valid = 1'b0; m_sel = '0;
        for (int n = 0; n < 300; n++) begin
            logic en, r, clr;
            int   idx;
            logic [7:0] ef;
            en  = ($urandom_range(0, 3) != 0);
            idx = $urandom_range(0, 7);
            r   = ($urandom_range(0, 29) == 0);
            clr = ($urandom_range(0, 11) == 0);
            rst = r; clear_seen = clr; set_in(en, idx);
            #1;
            ef = ref_f(en, idx);
            check("rand_f", {24'd0, F}, {24'd0, ef});
            if (r) begin
                m_fq = '0; m_valid = 1'b0; m_sel = '0; m_seen = '0;
            end else begin
                m_fq = ef; m_valid = en; m_sel = idx[2:0];
                m_seen = clr ? 8'h00 : (m_seen | ef);
            end
            tick();
            check("rand_fq",    {24'd0, F_q},    {24'd0, m_fq});
            check("rand_valid", {31'd0, valid_q}, {31'd0, m_valid});
            check("rand_sel",   {29'd0, sel_q},  {29'd0, m_sel});
            check("rand_seen",  {24'd0, seen_q}, {24'd0, m_seen});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
